// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU select codes, control bundle and
// default datapath widths.
package mips_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_XOR  = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_SLL  = 4'd11,
    ALU_SRL  = 4'd12
  } alu_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/operand_forward.sv
// Single-source forwarding mux: EX/MEM beats MEM/WB, register 0 is never
// forwarded, otherwise the registered read data passes through.
module operand_forward
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] data
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_reg_write & (exmem_rd != '0) & (exmem_rd == src);
  assign hit_memwb = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == src);

  always_comb begin
    if (hit_exmem)      data = exmem_result;
    else if (hit_memwb) data = memwb_result;
    else                data = reg_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard stall.
// Optional feature macro: ID_EX_FORWARD_EN (forwarding + load-use-only stall).
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [4:0]    id_shamt,
  input  logic [3:0]    id_alu_sel,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_shamt,
  output logic [3:0]    alu_sel,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_store_data,
  output logic          stall
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [4:0]    shamt;
    logic [3:0]    alu_sel;
    logic [RW-1:0] rd;
    ctrl_t         ctrl;
  } slot_t;

  slot_t         r;
  slot_t         id_slot;
  slot_t         bubble;
  logic          haz;
  logic          rt_is_src;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  // NOTE: every field gets a value on every pass, so no latch can be inferred.
  always_comb begin
    bubble               = '0;
    bubble.alu_sel       = ALU_AND;
    bubble.ctrl          = CTRL_BUBBLE;
    id_slot              = '0;
    id_slot.valid        = id_valid;
    id_slot.rs           = id_rs;
    id_slot.rt           = id_rt;
    id_slot.rs_data      = id_rs_data;
    id_slot.rt_data      = id_rt_data;
    id_slot.imm          = id_imm;
    id_slot.use_imm      = id_use_imm;
    id_slot.shamt        = id_shamt;
    id_slot.alu_sel      = id_alu_sel;
    id_slot.rd           = id_rd;
    id_slot.ctrl         = '{reg_write: id_reg_write, mem_read: id_mem_read,
                             mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};
  end

  // An immediate form does not read rt as an ALU source.
  assign rt_is_src = ~id_use_imm;

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    haz = id_valid & r.valid & r.ctrl.mem_read & (r.rd != '0) &
          ((r.rd == id_rs) | (rt_is_src & (r.rd == id_rt)));
  end
`else
  // Without forwarding, any pending write in EX or EX/MEM must drain first.
  function automatic logic raw_hit(input logic [RW-1:0] src);
    return (src != '0) &
           ((r.valid & r.ctrl.reg_write & (r.rd == src)) |
            (exmem_reg_write & (exmem_rd == src)));
  endfunction

  always_comb begin
    haz = 1'b0;
    if (id_valid) haz = raw_hit(id_rs) | (rt_is_src & raw_hit(id_rt));
  end
`endif

  assign stall = haz & ~flush & ~rst;

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst | flush | haz) r <= bubble;
    else                   r <= id_slot;
  end

`ifdef ID_EX_FORWARD_EN
  operand_forward #(.DW(DW), .RW(RW)) u_fwd_a (
    .src             (r.rs),
    .reg_data        (r.rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_a)
  );

  operand_forward #(.DW(DW), .RW(RW)) u_fwd_b (
    .src             (r.rt),
    .reg_data        (r.rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_b)
  );
`else
  assign fwd_a = r.rs_data;
  assign fwd_b = r.rt_data;

  // Result buses and source numbers have no reader when forwarding is absent.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, r.rs, r.rt};
`endif

  assign alu_a         = fwd_a;
  assign alu_b         = r.use_imm ? r.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_shamt     = r.shamt;
  assign alu_sel       = r.alu_sel;
  assign ex_valid      = r.valid;
  assign ex_reg_write  = r.ctrl.reg_write;
  assign ex_mem_read   = r.ctrl.mem_read;
  assign ex_mem_write  = r.ctrl.mem_write;
  assign ex_mem_to_reg = r.ctrl.mem_to_reg;
  assign ex_rd         = r.rd;

endmodule
